// File: rtl/spike_event_collector.sv
// Round-robin spike arbiter feeding a timestamped event FIFO, one grant per three cycles.
// Define SPIKE_EVENT_TIMESTAMP_EN to build the tick-driven timestamp counter; otherwise timestamps read as zero.
module spike_event_collector #(
  parameter int NUM_NEURONS = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int TS_WIDTH    = 16,
  localparam int ID_W  = $clog2(NUM_NEURONS),
  localparam int EV_W  = ID_W + TS_WIDTH,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic [NUM_NEURONS-1:0] spike_in,
  output logic [NUM_NEURONS-1:0] spike_ack,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [EV_W-1:0]        ev_data,
  output logic                   fifo_full,
  output logic [CNT_W-1:0]       fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr, rr_next, grant_id;
  logic                grant_found, push, pop;
  int                  rr_idx;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [EV_W-1:0]     mem [FIFO_DEPTH];
  logic [TS_WIDTH-1:0] ts_field;

`ifdef SPIKE_EVENT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ts <= '0;
    else if (tick) ts <= ts + 1'b1;
  end

  assign ts_field = ts;
`else
  logic tick_unused;

  assign tick_unused = tick;
  assign ts_field    = '0;
`endif

  // Search upward from the round-robin pointer, wrapping at NUM_NEURONS.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    rr_idx      = 0;
    for (int k = 0; k < NUM_NEURONS; k++) begin
      rr_idx = int'(rr_ptr) + k;
      if (rr_idx >= NUM_NEURONS) rr_idx = rr_idx - NUM_NEURONS;
      if (!grant_found && spike_in[ID_W'(rr_idx)]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(rr_idx);
      end
    end
  end

  assign rr_next    = (grant_id == ID_W'(NUM_NEURONS - 1)) ? '0 : grant_id + 1'b1;
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign ev_valid   = (fifo_count != '0);
  assign ev_data    = mem[rd_ptr];
  assign push       = (state_q == IDLE) && grant_found && !fifo_full;
  assign pop        = ev_valid && ev_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (push) state_d = ACK;
      ACK:     state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      spike_ack <= '0;
      rr_ptr    <= '0;
    end else begin
      state_q   <= state_d;
      spike_ack <= push ? (NUM_NEURONS'(1) << grant_id) : '0;
      if (push) rr_ptr <= rr_next;
    end
  end

  // Storage is left unreset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {grant_id, ts_field};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_event_collector.sv
// Self-checking bench for spike_event_collector: directed scenarios plus randomized traffic
// compared against a queue-based transaction model of arbitration and buffering.
module tb_spike_event_collector;

  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int TSW   = 16;
  localparam int ID_W  = 2;
  localparam int EV_W  = ID_W + TSW;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, tick, ev_ready;
  logic [N-1:0]     spike_in, spike_ack;
  logic             ev_valid, fifo_full;
  logic [EV_W-1:0]  ev_data;
  logic [CNT_W-1:0] fifo_count;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: arbitration pointer, blocked-cycle budget after a grant, event queue.
  int              m_ts, m_rr, m_cool;
  logic [EV_W-1:0] m_q[$];
  logic [N-1:0]    m_ack;
  logic [N-1:0]    drop1, drop2;
  bit              auto_drop;

  spike_event_collector #(.NUM_NEURONS(N), .FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .spike_in(spike_in), .spike_ack(spike_ack),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
    .fifo_full(fifo_full), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [TSW-1:0] model_ts();
`ifdef SPIKE_EVENT_TIMESTAMP_EN
    return TSW'(m_ts);
`else
    return '0;
`endif
  endfunction

  function automatic int onehot_index(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic reset_model();
    m_ts = 0; m_rr = 0; m_cool = 0; m_ack = '0;
    m_q.delete();
    drop1 = '0; drop2 = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; spike_in = '0; tick = 1'b0; ev_ready = 1'b0; auto_drop = 1'b0;
    reset_model();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Advance one clock: predict from pre-edge inputs, then let neurons release acknowledged requests.
  task automatic applyStimulus();
    int g, idx;
    bit do_pop;
    g = -1;
    do_pop = (m_q.size() > 0) && ev_ready;
    if (m_cool == 0 && m_q.size() < DEPTH && spike_in != '0)
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (g < 0 && spike_in[idx]) g = idx;
      end
    @(posedge clk); #1;
    if (do_pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back({ID_W'(g), model_ts()});
      m_ack  = N'(1) << g;
      m_rr   = (g + 1) % N;
      m_cool = 2;
    end else begin
      m_ack = '0;
      if (m_cool > 0) m_cool--;
    end
    if (tick) m_ts = (m_ts + 1) % (1 << TSW);
    if (auto_drop) begin
      spike_in = spike_in & ~drop2;
      drop2    = drop1;
      drop1    = spike_ack;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++; if (spike_ack !== '0) begin tests_failed++; $display("[TB] FAIL reset_ack: got %b expected 0", spike_ack); end
    tests_run++; if (ev_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", ev_valid); end
    tests_run++; if (fifo_full !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_full: got %b expected 0", fifo_full); end
    tests_run++; if (fifo_count !== '0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_single();
    logic [EV_W-1:0] exp_ev;
    apply_reset();
    tick = 1'b1;
    repeat (3) applyStimulus();
    tick = 1'b0;
    spike_in = 4'b0001;
    applyStimulus();
`ifdef SPIKE_EVENT_TIMESTAMP_EN
    exp_ev = {2'd0, 16'd3};
`else
    exp_ev = {2'd0, 16'd0};
`endif
    tests_run++; if (spike_ack !== 4'b0001) begin tests_failed++; $display("[TB] FAIL single_ack: got %b expected 0001", spike_ack); end
    tests_run++; if (ev_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_valid: got %b expected 1", ev_valid); end
    tests_run++; if (ev_data !== exp_ev) begin tests_failed++; $display("[TB] FAIL single_data: got %h expected %h", ev_data, exp_ev); end
    spike_in = '0;
    applyStimulus();
    tests_run++; if (spike_ack !== 4'b0000) begin tests_failed++; $display("[TB] FAIL single_ack_drop: got %b expected 0000", spike_ack); end
    tests_run++; if (ev_data !== exp_ev) begin tests_failed++; $display("[TB] FAIL single_hold: got %h expected %h", ev_data, exp_ev); end
    ev_ready = 1'b1;
    applyStimulus();
    ev_ready = 1'b0;
    tests_run++; if (ev_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_pop_valid: got %b expected 0", ev_valid); end
    tests_run++; if (fifo_count !== '0) begin tests_failed++; $display("[TB] FAIL single_pop_count: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_contention();
    int order[$];
    int cycles[$];
    apply_reset();
    auto_drop = 1'b1;
    spike_in  = 4'b1111;
    for (int c = 0; c < 20 && order.size() < 4; c++) begin
      applyStimulus();
      tests_run++; if (spike_ack !== m_ack) begin tests_failed++; $display("[TB] FAIL contention_ack: got %b expected %b", spike_ack, m_ack); end
      if (spike_ack != '0) begin
        order.push_back(onehot_index(spike_ack));
        cycles.push_back(c);
      end
    end
    tests_run++; if (order.size() != 4) begin tests_failed++; $display("[TB] FAIL contention_grants: got %0d expected 4", order.size()); end
    for (int i = 0; i < order.size(); i++) begin
      tests_run++; if (order[i] != i) begin tests_failed++; $display("[TB] FAIL contention_order: got %0d expected %0d", order[i], i); end
      if (i > 0) begin
        tests_run++; if (cycles[i] - cycles[i-1] != 3) begin tests_failed++; $display("[TB] FAIL contention_spacing: got %0d expected 3", cycles[i] - cycles[i-1]); end
      end
    end
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (ev_valid !== 1'b1 || ev_data[EV_W-1 -: ID_W] !== ID_W'(i)) begin tests_failed++; $display("[TB] FAIL contention_pop_id: got %b/%0d expected 1/%0d", ev_valid, ev_data[EV_W-1 -: ID_W], i); end
      applyStimulus();
    end
    ev_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int raised, acks, waited, popped;
    apply_reset();
    auto_drop = 1'b1;
    raised = 0; acks = 0;
    for (int c = 0; c < 60; c++) begin
      if (!spike_in[2] && !drop1[2] && !drop2[2] && raised < 9) begin spike_in[2] = 1'b1; raised++; end
      tick = 1'($urandom_range(0, 1));
      applyStimulus();
      if (spike_ack[2]) acks++;
    end
    tick = 1'b0;
    tests_run++; if (acks != 8) begin tests_failed++; $display("[TB] FAIL bp_acks: got %0d expected 8", acks); end
    tests_run++; if (fifo_full !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_full: got %b expected 1", fifo_full); end
    tests_run++; if (fifo_count !== 4'd8) begin tests_failed++; $display("[TB] FAIL bp_count: got %0d expected 8", fifo_count); end
    tests_run++; if (ev_data !== m_q[0]) begin tests_failed++; $display("[TB] FAIL bp_head: got %h expected %h", ev_data, m_q[0]); end
    ev_ready = 1'b1;
    applyStimulus();
    ev_ready = 1'b0;
    waited = 1;
    while (!spike_ack[2] && waited < 10) begin
      applyStimulus();
      waited++;
    end
    tests_run++; if (waited != 2) begin tests_failed++; $display("[TB] FAIL bp_ack_delay: got %0d expected 2", waited); end
    tests_run++; if (fifo_count !== 4'd8) begin tests_failed++; $display("[TB] FAIL bp_refill: got %0d expected 8", fifo_count); end
    popped = 1;
    ev_ready = 1'b1;
    for (int c = 0; c < 20 && ev_valid; c++) begin
      tests_run++; if (ev_data !== m_q[0] || ev_data[EV_W-1 -: ID_W] !== 2'd2) begin tests_failed++; $display("[TB] FAIL bp_drain: got %h expected %h", ev_data, m_q[0]); end
      applyStimulus();
      popped++;
    end
    ev_ready = 1'b0;
    tests_run++; if (popped != 9) begin tests_failed++; $display("[TB] FAIL bp_total: got %0d expected 9", popped); end
  endtask

  task automatic test_wrap();
    logic [EV_W-1:0] exp1, exp2;
    int waited;
    apply_reset();
    tick = 1'b1;
    repeat (65535) applyStimulus();
    spike_in = 4'b0001;
    applyStimulus();
    tick = 1'b0;
    spike_in = 4'b0010;
`ifdef SPIKE_EVENT_TIMESTAMP_EN
    exp1 = {2'd0, 16'hFFFF};
`else
    exp1 = {2'd0, 16'h0000};
`endif
    exp2 = {2'd1, 16'h0000};
    tests_run++; if (ev_data !== exp1) begin tests_failed++; $display("[TB] FAIL wrap_first: got %h expected %h", ev_data, exp1); end
    waited = 0;
    while (!spike_ack[1] && waited < 8) begin
      applyStimulus();
      waited++;
    end
    spike_in = '0;
    tests_run++; if (fifo_count !== 4'd2) begin tests_failed++; $display("[TB] FAIL wrap_count: got %0d expected 2", fifo_count); end
    ev_ready = 1'b1;
    applyStimulus();
    ev_ready = 1'b0;
    tests_run++; if (ev_data !== exp2) begin tests_failed++; $display("[TB] FAIL wrap_second: got %h expected %h", ev_data, exp2); end
  endtask

  task automatic test_reset_during_ack();
    apply_reset();
    spike_in = 4'b0100;
    applyStimulus();
    tests_run++; if (spike_ack !== 4'b0100) begin tests_failed++; $display("[TB] FAIL rack_pre: got %b expected 0100", spike_ack); end
    #2 rst = 1'b1;
    #1;
    tests_run++; if (spike_ack !== '0) begin tests_failed++; $display("[TB] FAIL rack_ack: got %b expected 0", spike_ack); end
    tests_run++; if (ev_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rack_valid: got %b expected 0", ev_valid); end
    tests_run++; if (fifo_count !== '0) begin tests_failed++; $display("[TB] FAIL rack_count: got %0d expected 0", fifo_count); end
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
    spike_in = 4'b1111;
    applyStimulus();
    spike_in = '0;
    tests_run++; if (spike_ack !== 4'b0001) begin tests_failed++; $display("[TB] FAIL rack_rr: got %b expected 0001", spike_ack); end
  endtask

  task automatic test_random();
    apply_reset();
    auto_drop = 1'b1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!spike_in[i] && !drop1[i] && !drop2[i] && $urandom_range(0, 3) == 0) spike_in[i] = 1'b1;
      tick     = 1'($urandom_range(0, 1));
      ev_ready = ($urandom_range(0, 2) == 0);
      applyStimulus();
      tests_run++; if (spike_ack !== m_ack) begin tests_failed++; $display("[TB] FAIL rand_ack: got %b expected %b", spike_ack, m_ack); end
      tests_run++; if (fifo_count !== CNT_W'(m_q.size())) begin tests_failed++; $display("[TB] FAIL rand_count: got %0d expected %0d", fifo_count, m_q.size()); end
      tests_run++; if (fifo_full !== (m_q.size() == DEPTH)) begin tests_failed++; $display("[TB] FAIL rand_full: got %b expected %b", fifo_full, m_q.size() == DEPTH); end
      tests_run++; if (ev_valid !== (m_q.size() > 0)) begin tests_failed++; $display("[TB] FAIL rand_valid: got %b expected %b", ev_valid, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        tests_run++; if (ev_data !== m_q[0]) begin tests_failed++; $display("[TB] FAIL rand_data: got %h expected %h", ev_data, m_q[0]); end
      end
    end
    ev_ready = 1'b0;
    spike_in = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_wrap();
    test_reset_during_ack();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spike_event_collector.md
SPIKE_EVENT_COLLECTOR -- requirements
Module: spike_event_collector

Interface
REQ-001 Parameter NUM_NEURONS, default 4; number of upstream neuron channels; range 2..16.
REQ-002 Parameter FIFO_DEPTH, default 8; event FIFO entries; power of two, at least 2.
REQ-003 Parameter TS_WIDTH, default 16; timestamp counter width.
REQ-004 Derived ID_W = clog2(NUM_NEURONS); EV_W = ID_W + TS_WIDTH.
REQ-005 Port clk, input, 1; clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1; reset, asynchronous, active-high.
REQ-007 Port tick, input, 1; timestep strobe; each high cycle advances the timestamp.
REQ-008 Port spike_in, input, NUM_NEURONS; level spike request per neuron; held until acknowledged.
REQ-009 Port spike_ack, output, NUM_NEURONS; per-neuron acknowledge; registered; one-hot or zero.
REQ-010 Port ev_valid, output, 1; FIFO non-empty; ev_data is valid.
REQ-011 Port ev_ready, input, 1; consumer accepts the head event when ev_valid and ev_ready are both high.
REQ-012 Port ev_data, output, EV_W; head event {id[ID_W-1:0], timestamp[TS_WIDTH-1:0]}, id in the MSBs.
REQ-013 Port fifo_full, output, 1; FIFO occupancy equals FIFO_DEPTH.
REQ-014 Port fifo_count, output, clog2(FIFO_DEPTH)+1; current occupancy.

Function
REQ-015 Timestamp counter ts SHALL increment by 1 on each clk edge with tick high, wrapping from 2^TS_WIDTH-1 to 0.
REQ-016 The FSM SHALL have exactly three states: IDLE, ACK and HOLD.
REQ-017 IDLE: if any spike_in bit is high and fifo_full is low, the block SHALL grant one neuron by round-robin, push {id, ts}, register spike_ack[id]=1 and move to ACK; otherwise it stays in IDLE.
REQ-018 The pushed timestamp SHALL be the ts value before any increment in the same cycle.
REQ-019 ACK: spike_ack SHALL be high for exactly this one cycle, then return to 0; the next state is HOLD unconditionally.
REQ-020 HOLD: no grant is made; this masks the one-cycle trailing spike of the acknowledged neuron; the next state is IDLE.
REQ-021 Minimum spacing between successive grants SHALL be 3 cycles, so sustained throughput is one event per 3 cycles.
REQ-022 Round-robin: a pointer starts at 0; the search begins at the pointer index and ascends with wrap; after granting i, the pointer becomes (i+1) mod NUM_NEURONS.
REQ-023 FIFO full in IDLE: no grant and no ack; requests are held (backpressure); no event is ever dropped.
REQ-024 The full decision SHALL use the registered occupancy; a pop in the same cycle does not enable a push.
REQ-025 Simultaneous push and pop SHALL leave fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-026 Pop: ev_valid and ev_ready are both high; ev_valid is low when empty, and ev_ready when empty has no effect.
REQ-027 An event pushed at edge k SHALL be visible on ev_data with ev_valid high after edge k (latency 1).
REQ-028 ev_data SHALL be held stable while ev_valid is high and ev_ready is low.

Reset
REQ-029 On rst: state=IDLE, spike_ack=0, ts=0, RR pointer=0, FIFO pointers/count=0, ev_valid=0, fifo_full=0, fifo_count=0.
REQ-030 Reset mid-ACK SHALL drop spike_ack immediately and discard all buffered events.
REQ-031 ev_data is don't-care while ev_valid is low.

Configuration
REQ-032 Macro SPIKE_EVENT_TIMESTAMP_EN defined: the timestamp field carries ts per REQ-015/018.
REQ-033 Macro SPIKE_EVENT_TIMESTAMP_EN undefined: the ts counter is not implemented, tick is ignored, and the timestamp field of every event is all zeros; ports and EV_W are unchanged.

Verification
REQ-034 Single: reset, 3 ticks, spike_in=0001 -> spike_ack=0001 for one cycle, event {0,3}, ev_valid next cycle.
REQ-035 Contention: spike_in=1111 held and dropped per ack -> grant order 0,1,2,3; grants 3 cycles apart.
REQ-036 Backpressure: ev_ready=0, 9 spikes from neuron 2 -> 8 events, fifo_full=1, 9th request unacknowledged; one pop -> 9th acked 2 cycles later with no loss.
REQ-037 Wrap: ts=0xFFFF with tick high, spike in the same cycle -> event ts=0xFFFF, next event ts=0x0000.
REQ-038 Reset during ACK -> spike_ack=0 and ev_valid=0 immediately, fifo_count=0.
REQ-039 Macro undefined: ticks and spikes -> all event timestamps 0, ids still correct.
